// File: rtl/uart_boot_loader.sv
// ---------------------------------------------------------------------------
// uart_boot_loader
//
// Receives a program image over an 8N1 UART link and writes it word by word
// into instruction memory. The core is held in reset until the whole image
// has been written, so it starts fetching at word 0 of a fully loaded memory.
//
// Frame on the wire:
//   SYNC_BYTE, LEN_L, LEN_H, (LEN+1) words of 4 bytes little-endian, [CHK]
//
// Build option:
//   BOOT_CHECKSUM_EN  when defined, a trailing byte must equal the XOR of
//                     LEN_L, LEN_H and every data byte; otherwise the load
//                     is rejected. When undefined there is no CHK byte.
//
// Parameters:
//   CLK_FREQ   clock frequency in Hz
//   BAUD       UART bit rate (CLK_FREQ/BAUD must be >= 8)
//   ADDR_W     instruction-memory word-address width (<= 16)
//   SYNC_BYTE  byte that opens a load frame
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   uart_rx     serial input, idle high, asynchronous to clk
//   imem_we     one-cycle write strobe to instruction memory
//   imem_addr   word address of the current write (held between writes)
//   imem_wdata  instruction word (held between writes)
//   core_rst_n  active-low reset to the core, released after DONE
//   busy        a frame is being received (LEN/DATA/CHK)
//   done        image loaded (sticky until rst_n)
//   err         load rejected (sticky until rst_n)
// ---------------------------------------------------------------------------
module uart_boot_loader #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned      DIV       = CLK_FREQ / BAUD;
    localparam int unsigned      CNT_W     = $clog2(DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam int unsigned      CAPACITY  = 2 ** ADDR_W;

    // -----------------------------------------------------------------------
    // UART receiver
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_valid;
    logic             frame_err;

    // The synchroniser and edge-detect stages reset to the idle-line level so
    // that leaving reset never looks like a start bit.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Mid start bit: a high line means the falling edge was a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    byte_valid = rx_sync_q;
                    frame_err  = !rx_sync_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Frame state machine, word assembler and address counter
    // -----------------------------------------------------------------------
`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_L, ST_LEN_H, ST_DATA, ST_CHK, ST_DONE, ST_ERR
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_L, ST_LEN_H, ST_DATA, ST_DONE, ST_ERR
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic [7:0]        chk_q, chk_d;
    logic [7:0]        rx_byte;
    logic [15:0]       len_full;

    assign rx_byte  = rx_shift_q;
    assign len_full = {rx_byte, len_lo_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            word_cnt_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_n_q <= 1'b0;
            chk_q        <= '0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            word_cnt_q   <= word_cnt_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_n_q <= core_rst_n_d;
            chk_q        <= chk_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        word_cnt_d   = word_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        chk_d        = chk_q;
        // Registered from the current state: rises the cycle after DONE entry.
        core_rst_n_d = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (byte_valid && rx_byte == SYNC_BYTE) begin
                    word_cnt_d = '0;
                    byte_idx_d = '0;
                    chk_d      = '0;
                    state_d    = ST_LEN_L;
                end
            end
            ST_LEN_L: begin
                if (frame_err) begin
                    state_d = ST_ERR;
                end else if (byte_valid) begin
                    len_lo_d = rx_byte;
                    chk_d    = chk_q ^ rx_byte;
                    state_d  = ST_LEN_H;
                end
            end
            ST_LEN_H: begin
                if (frame_err) begin
                    state_d = ST_ERR;
                end else if (byte_valid) begin
                    chk_d = chk_q ^ rx_byte;
                    // The last word index must fit in the address space.
                    if ({16'd0, len_full} >= CAPACITY) begin
                        state_d = ST_ERR;
                    end else begin
                        len_d   = len_full[ADDR_W-1:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (frame_err) begin
                    state_d = ST_ERR;
                end else if (imem_we_q) begin
                    // Strobe cycle: either the image is complete or advance the address.
                    if (word_cnt_q == len_q) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        word_cnt_d = word_cnt_q + ADDR_W'(1);
                    end
                end else if (byte_valid) begin
                    chk_d      = chk_q ^ rx_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_cnt_q;
                        imem_wdata_d = {rx_byte, asm_q};
                    end else begin
                        // Bytes enter at the top so byte 0 ends up in bits [7:0].
                        asm_d = {rx_byte, asm_q[23:8]};
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CHK: begin
                if (frame_err) begin
                    state_d = ST_ERR;
                end else if (byte_valid) begin
                    state_d = (rx_byte == chk_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        case (state_q)
            ST_LEN_L, ST_LEN_H, ST_DATA: busy = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            ST_CHK: busy = 1'b1;
`endif
            default: busy = 1'b0;
        endcase
    end

    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERR);
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst_n = core_rst_n_q;

endmodule
